fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 27 ++
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if -- control and instruction-memory signals of the fetch sequencer.
//   slave modport  : seen by the sequencer (start/stall/redirect/instr in, fetch results out)
//   master modport : seen by the driver of the sequencer (testbench or pipeline)
interface fetch_sequencer_if;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] instr;
  logic [31:0] pc_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;

  modport slave (
    input  start, stall, redirect_valid, redirect_addr, instr,
    output pc_addr, if_valid, if_instr, if_pc, halted, fault, fetch_count
  );

  modport master (
    output start, stall, redirect_valid, redirect_addr, instr,
    input  pc_addr, if_valid, if_instr, if_pc, halted, fault, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- instruction fetch stage with IDLE/RUN/HALT control.
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : fetch_sequencer_if.slave
//            in : start, stall, redirect_valid, redirect_addr[31:0], instr[31:0]
//            out: pc_addr[31:0], if_valid, if_instr[31:0], if_pc[31:0],
//                 halted, fault (sticky), fetch_count[15:0] (saturating)
// Memory is combinational: instr corresponds to pc_addr in the same cycle and
// is captured into if_instr on the next rising edge.
module fetch_sequencer #(
  parameter int         SIZE_IM = 128,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // PC parked here while idle so memory returns its halt word.
  localparam logic [31:0] IDLE_PC  = 32'hFFFF_FFFC;
  localparam logic [29:0] IM_LIMIT = 30'(SIZE_IM);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_fault;
  logic [15:0] r_fetch_count;

  logic        w_out_of_range;
  logic        w_halt_op;

  assign w_out_of_range = (r_pc[31:2] >= IM_LIMIT);
  assign w_halt_op      = (bus.instr[31:26] == HALT_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= IDLE_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'hFC00_0000;
      r_if_pc       <= 32'h0;
      r_fault       <= 1'b0;
      r_fetch_count <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          // Stall and redirect have no effect outside RUN.
          r_if_valid <= 1'b0;
          if (bus.start) begin
            r_state       <= S_RUN;
            r_pc          <= 32'h0;
            r_fault       <= 1'b0;
            r_fetch_count <= 16'h0;
          end
        end
        S_RUN: begin
          if (bus.redirect_valid) begin
            // Word-align the target; the instruction in flight is dropped.
            r_pc       <= {bus.redirect_addr[31:2], 2'b00};
            r_if_valid <= 1'b0;
          end else if (bus.stall) begin
            // Hold every piece of fetch state.
          end else if (w_out_of_range) begin
            // Range check comes before halt decode: instr is meaningless here.
            r_fault    <= 1'b1;
            r_state    <= S_HALT;
            r_if_valid <= 1'b0;
          end else if (w_halt_op) begin
            r_state    <= S_HALT;
            r_if_valid <= 1'b0;
          end else begin
            r_if_instr <= bus.instr;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + 32'd4;
            if (r_fetch_count != 16'hFFFF) begin
              r_fetch_count <= r_fetch_count + 16'd1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_pc       <= IDLE_PC;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_addr     = r_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_instr    = r_if_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.fault       = r_fault;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer -- directed self-checking bench for fetch_sequencer.
// dut1 uses the default memory depth (128 words); dut2 uses SIZE_IM = 4 for
// the out-of-range fault case. Both share clk and reset.
module tb_fetch_sequencer;

  logic clk;
  logic reset;

  fetch_sequencer_if bus1();
  fetch_sequencer_if bus2();

  fetch_sequencer #(.SIZE_IM(128)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  fetch_sequencer #(.SIZE_IM(4)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  // Combinational instruction memories; anything beyond returns a halt word.
  logic [31:0] mem1 [0:127];
  logic [31:0] mem2 [0:7];

  assign bus1.instr = (bus1.pc_addr[31:9] == 23'd0) ? mem1[bus1.pc_addr[8:2]] : HALT_WORD;
  assign bus2.instr = (bus2.pc_addr[31:5] == 27'd0) ? mem2[bus2.pc_addr[4:2]] : HALT_WORD;

  int n_cmp;
  int n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[ok] %s = %h", tag, got);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] add_word(input int i);
    add_word = 32'h0000_0020 | (32'(i & 31) << 11);
  endfunction

  task automatic idle_inputs();
    bus1.start = 1'b0; bus1.stall = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_addr = 32'h0;
    bus2.start = 1'b0; bus2.stall = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_addr = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 128; i++) mem1[i] = add_word(i);
    for (int i = 0; i < 8; i++)   mem2[i] = add_word(i + 40);
    mem1[3] = HALT_WORD;

    // ---------------- reset state ----------------
    do_reset();
    check_eq("rst_pc",       bus1.pc_addr, 32'hFFFF_FFFC);
    check_eq("rst_valid",    32'(bus1.if_valid), 32'd0);
    check_eq("rst_if_instr", bus1.if_instr, 32'hFC00_0000);
    check_eq("rst_if_pc",    bus1.if_pc, 32'h0);
    check_eq("rst_fault",    32'(bus1.fault), 32'd0);
    check_eq("rst_count",    32'(bus1.fetch_count), 32'd0);
    check_eq("rst_halted",   32'(bus1.halted), 32'd0);
    tick();
    check_eq("idle_hold_pc", bus1.pc_addr, 32'hFFFF_FFFC);

    // ---------------- basic run to halt word ----------------
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check_eq("run_pc0",    bus1.pc_addr, 32'h0);
    check_eq("run_valid0", 32'(bus1.if_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("run_valid_%0d", k), 32'(bus1.if_valid), 32'd1);
      check_eq($sformatf("run_if_pc_%0d", k), bus1.if_pc, 32'(4 * k));
      check_eq($sformatf("run_instr_%0d", k), bus1.if_instr, add_word(k));
    end
    tick();
    check_eq("halt_halted", 32'(bus1.halted), 32'd1);
    check_eq("halt_valid",  32'(bus1.if_valid), 32'd0);
    check_eq("halt_count",  32'(bus1.fetch_count), 32'd3);
    check_eq("halt_pc",     bus1.pc_addr, 32'd12);
    // Stall/redirect are ignored while halted; start in RUN ignored later.
    bus1.redirect_valid = 1'b1; bus1.redirect_addr = 32'h40;
    tick();
    bus1.redirect_valid = 1'b0;
    check_eq("halt_ign_redir", bus1.pc_addr, 32'd12);
    check_eq("halt_still",     32'(bus1.halted), 32'd1);

    // ---------------- redirect at PC 8 ----------------
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check_eq("restart_pc", bus1.pc_addr, 32'h0);
    check_eq("restart_count", 32'(bus1.fetch_count), 32'd0);
    tick();
    bus1.start = 1'b1;   // must be ignored in RUN
    tick();
    bus1.start = 1'b0;
    check_eq("start_in_run_pc", bus1.pc_addr, 32'h8);
    bus1.redirect_valid = 1'b1; bus1.redirect_addr = 32'h0000_002B;
    tick();
    bus1.redirect_valid = 1'b0;
    check_eq("redir_pc",     bus1.pc_addr, 32'h28);
    check_eq("redir_bubble", 32'(bus1.if_valid), 32'd0);
    tick();
    check_eq("redir_valid",  32'(bus1.if_valid), 32'd1);
    check_eq("redir_if_pc",  bus1.if_pc, 32'h28);
    check_eq("redir_instr",  bus1.if_instr, add_word(10));
    check_eq("redir_count",  32'(bus1.fetch_count), 32'd3);

    // ---------------- stall at PC 4 ----------------
    do_reset();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick();
    check_eq("stall_pre_pc", bus1.pc_addr, 32'h4);
    bus1.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("stall_pc_%0d", k),    bus1.pc_addr, 32'h4);
      check_eq($sformatf("stall_instr_%0d", k), bus1.if_instr, add_word(0));
      check_eq($sformatf("stall_count_%0d", k), 32'(bus1.fetch_count), 32'd1);
      check_eq($sformatf("stall_valid_%0d", k), 32'(bus1.if_valid), 32'd1);
    end
    bus1.redirect_valid = 1'b1; bus1.redirect_addr = 32'h20;
    tick();
    bus1.redirect_valid = 1'b0;
    bus1.stall = 1'b0;
    check_eq("stall_redir_pc",    bus1.pc_addr, 32'h20);
    check_eq("stall_redir_valid", 32'(bus1.if_valid), 32'd0);
    tick();
    check_eq("stall_after_if_pc", bus1.if_pc, 32'h20);
    check_eq("stall_after_count", 32'(bus1.fetch_count), 32'd2);

    // ---------------- reset overrides everything mid-RUN ----------------
    reset = 1'b1; bus1.stall = 1'b1; bus1.redirect_valid = 1'b1;
    bus1.redirect_addr = 32'h80; bus1.start = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check_eq("rstrun_pc",     bus1.pc_addr, 32'hFFFF_FFFC);
    check_eq("rstrun_valid",  32'(bus1.if_valid), 32'd0);
    check_eq("rstrun_count",  32'(bus1.fetch_count), 32'd0);
    check_eq("rstrun_halted", 32'(bus1.halted), 32'd0);
    tick();
    check_eq("rstrun_idle_pc", bus1.pc_addr, 32'hFFFF_FFFC);

    // ---------------- SIZE_IM = 4 fault ----------------
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("flt_if_pc_%0d", k), bus2.if_pc, 32'(4 * k));
      check_eq($sformatf("flt_valid_%0d", k), 32'(bus2.if_valid), 32'd1);
    end
    check_eq("flt_nofault_yet", 32'(bus2.fault), 32'd0);
    tick();
    check_eq("flt_fault",  32'(bus2.fault), 32'd1);
    check_eq("flt_halted", 32'(bus2.halted), 32'd1);
    check_eq("flt_count",  32'(bus2.fetch_count), 32'd4);
    check_eq("flt_valid",  32'(bus2.if_valid), 32'd0);
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    check_eq("flt_clr_fault", 32'(bus2.fault), 32'd0);
    check_eq("flt_clr_pc",    bus2.pc_addr, 32'h0);
    check_eq("flt_clr_count", 32'(bus2.fetch_count), 32'd0);

    // ---------------- fetch_count saturation ----------------
    do_reset();
    mem1[3] = add_word(3);
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    cyc = 0;
    while (bus1.fetch_count != 16'hFFFF && cyc < 70000) begin
      bus1.redirect_valid = (bus1.pc_addr == 32'd508);
      bus1.redirect_addr  = 32'h0;
      tick();
      cyc++;
    end
    check_eq("sat_reached", 32'(bus1.fetch_count), 32'h0000_FFFF);
    for (int k = 0; k < 300; k++) begin
      bus1.redirect_valid = (bus1.pc_addr == 32'd508);
      bus1.redirect_addr  = 32'h0;
      tick();
    end
    bus1.redirect_valid = 1'b0;
    check_eq("sat_hold",   32'(bus1.fetch_count), 32'h0000_FFFF);
    check_eq("sat_fault",  32'(bus1.fault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
